// File: rtl/pipelined_csel_alu_pkg.sv
// Shared constants and helpers for the pipelined carry-select ALU.
// B-input select encodings, block-count helper and saturation limits.
package pipelined_csel_alu_pkg;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_NB   = 2'b10;
  localparam logic [1:0] SEL_ONES = 2'b11;

  // Widest datapath the saturation helpers can describe.
  localparam int unsigned MaxWidth = 256;

  function automatic int unsigned calc_nblk(int unsigned width, int unsigned blk);
    return width / blk;
  endfunction

  // Largest positive two's-complement value of the given width (0x7F..F).
  function automatic logic [MaxWidth-1:0] sat_pos_limit(int unsigned width);
    return (MaxWidth'(1) << (width - 1)) - MaxWidth'(1);
  endfunction

  // Most negative two's-complement value of the given width (0x80..0).
  function automatic logic [MaxWidth-1:0] sat_neg_limit(int unsigned width);
    return MaxWidth'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: adds a and y for both possible carry-ins and also
// reports the carry into the block MSB for each case (needed for overflow).
module csel_block
  import pipelined_csel_alu_pkg::*;
#(
  parameter int unsigned BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] y,
  output logic [BLK-1:0] sum0,
  output logic [BLK-1:0] sum1,
  output logic           cout0,
  output logic           cout1,
  output logic           cmsb0,
  output logic           cmsb1
);

  always_comb begin
    {cout0, sum0} = {1'b0, a} + {1'b0, y};
    {cout1, sum1} = {1'b0, a} + {1'b0, y} + (BLK + 1)'(1);
    // Carry into the MSB falls out of the MSB sum bit: s = a ^ y ^ c.
    cmsb0 = a[BLK-1] ^ y[BLK-1] ^ sum0[BLK-1];
    cmsb1 = a[BLK-1] ^ y[BLK-1] ^ sum1[BLK-1];
  end

endmodule

// File: rtl/pipelined_csel_alu.sv
// Two-stage pipelined carry-select A+Y+Cin unit with valid/ready on both sides.
// Optional saturation on signed overflow when PIPELINED_CSEL_ALU_SAT_EN is defined.
module pipelined_csel_alu
  import pipelined_csel_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       S,
  input  logic             Cin,
`ifdef PIPELINED_CSEL_ALU_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] G,
  output logic             Cout,
  output logic             V,
  output logic             Z,
  output logic             N
);

  localparam int unsigned NBLK = calc_nblk(WIDTH, BLK);

  if ((WIDTH % BLK) != 0 || NBLK < 2) begin : g_bad_params
    $error("pipelined_csel_alu: WIDTH must be a multiple of BLK and at least 2*BLK");
  end

  // Stage 1 combinational: B-input select and per-block sums
  logic [WIDTH-1:0] y;

  always_comb begin
    y = '0;
    unique case (S)
      SEL_ZERO: y = '0;
      SEL_B:    y = B;
      SEL_NB:   y = ~B;
      SEL_ONES: y = '1;
    endcase
  end

  logic [BLK-1:0] b0_sum;
  logic           b0_cout;

  assign {b0_cout, b0_sum} = {1'b0, A[BLK-1:0]} + {1'b0, y[BLK-1:0]} + {{BLK{1'b0}}, Cin};

  logic [NBLK-1:1][BLK-1:0] nb_sum0, nb_sum1;
  logic [NBLK-1:1]          nb_cout0, nb_cout1, nb_cmsb0, nb_cmsb1;

  for (genvar k = 1; k < NBLK; k++) begin : g_blk
    csel_block #(
      .BLK(BLK)
    ) u_blk (
      .a    (A[k*BLK +: BLK]),
      .y    (y[k*BLK +: BLK]),
      .sum0 (nb_sum0[k]),
      .sum1 (nb_sum1[k]),
      .cout0(nb_cout0[k]),
      .cout1(nb_cout1[k]),
      .cmsb0(nb_cmsb0[k]),
      .cmsb1(nb_cmsb1[k])
    );
  end

  // Handshake
  logic s1_valid;
  logic s1_adv, s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1 registers
  logic [BLK-1:0]           s1_b0_sum;
  logic                     s1_b0_cout;
  logic [NBLK-1:1][BLK-1:0] s1_sum0, s1_sum1;
  logic [NBLK-1:1]          s1_cout0, s1_cout1, s1_cmsb0, s1_cmsb1;
`ifdef PIPELINED_CSEL_ALU_SAT_EN
  logic                     s1_sat, s1_a_msb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_b0_sum  <= '0;
      s1_b0_cout <= 1'b0;
      s1_sum0    <= '0;
      s1_sum1    <= '0;
      s1_cout0   <= '0;
      s1_cout1   <= '0;
      s1_cmsb0   <= '0;
      s1_cmsb1   <= '0;
`ifdef PIPELINED_CSEL_ALU_SAT_EN
      s1_sat     <= 1'b0;
      s1_a_msb   <= 1'b0;
`endif
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_b0_sum  <= b0_sum;
        s1_b0_cout <= b0_cout;
        s1_sum0    <= nb_sum0;
        s1_sum1    <= nb_sum1;
        s1_cout0   <= nb_cout0;
        s1_cout1   <= nb_cout1;
        s1_cmsb0   <= nb_cmsb0;
        s1_cmsb1   <= nb_cmsb1;
`ifdef PIPELINED_CSEL_ALU_SAT_EN
        s1_sat     <= sat;
        s1_a_msb   <= A[WIDTH-1];
`endif
      end
    end
  end

  // Only the top block's MSB carry feeds V; lower ones are kept for symmetry.
  if (NBLK > 2) begin : g_unused_cmsb
    logic unused_cmsb;
    assign unused_cmsb = ^{s1_cmsb0[NBLK-2:1], s1_cmsb1[NBLK-2:1]};
  end

  // Stage 2 combinational: ripple-select across blocks; c[k] is block k's carry-in
  logic [NBLK:1]    c;
  logic [WIDTH-1:0] g_sel, g_fin;
  logic             c_msb, v_sel;

  assign c[1]             = s1_b0_cout;
  assign g_sel[BLK-1:0]   = s1_b0_sum;

  for (genvar k = 1; k < NBLK; k++) begin : g_sel_chain
    assign g_sel[k*BLK +: BLK] = c[k] ? s1_sum1[k]  : s1_sum0[k];
    assign c[k+1]              = c[k] ? s1_cout1[k] : s1_cout0[k];
  end

  assign c_msb = c[NBLK-1] ? s1_cmsb1[NBLK-1] : s1_cmsb0[NBLK-1];
  assign v_sel = c[NBLK] ^ c_msb;

`ifdef PIPELINED_CSEL_ALU_SAT_EN
  localparam logic [WIDTH-1:0] SatPos = WIDTH'(sat_pos_limit(WIDTH));
  localparam logic [WIDTH-1:0] SatNeg = WIDTH'(sat_neg_limit(WIDTH));

  // Overflow direction follows A's sign: A and Y must share it to overflow.
  assign g_fin = (s1_sat && v_sel) ? (s1_a_msb ? SatNeg : SatPos) : g_sel;
`else
  assign g_fin = g_sel;
`endif

  // Stage 2 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      G         <= '0;
      Cout      <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
      N         <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        G    <= g_fin;
        Cout <= c[NBLK];
        V    <= v_sel;
        Z    <= (g_fin == '0);
        N    <= g_fin[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_csel_alu.sv
// Directed bench for pipelined_csel_alu (32/4 and 16/8 instances) with a
// scoreboard on the output handshake; covers PIPELINED_CSEL_ALU_SAT_EN when defined.
module tb_pipelined_csel_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, g;
  logic [1:0]  s;
  logic        cin, cout, v, z, n;
`ifdef PIPELINED_CSEL_ALU_SAT_EN
  logic        sat;
`endif

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, g16;
  logic [1:0]  s16;
  logic        cin16, cout16, v16, z16, n16;

  pipelined_csel_alu #(
    .WIDTH(32),
    .BLK  (4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .S        (s),
    .Cin      (cin),
`ifdef PIPELINED_CSEL_ALU_SAT_EN
    .sat      (sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .G        (g),
    .Cout     (cout),
    .V        (v),
    .Z        (z),
    .N        (n)
  );

  pipelined_csel_alu #(
    .WIDTH(16),
    .BLK  (8)
  ) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid16),
    .in_ready (in_ready16),
    .A        (a16),
    .B        (b16),
    .S        (s16),
    .Cin      (cin16),
`ifdef PIPELINED_CSEL_ALU_SAT_EN
    .sat      (1'b0),
`endif
    .out_valid(out_valid16),
    .out_ready(out_ready16),
    .G        (g16),
    .Cout     (cout16),
    .V        (v16),
    .Z        (z16),
    .N        (n16)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Hand-computed vectors; flags are {Cout, V, Z, N}.
  logic [31:0] vec_a [16] = '{32'h0000_0001, 32'h0000_000A, 32'h0000_0003, 32'h1234_5678,
                              32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000,
                              32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0F0F_0F0F,
                              32'h0F0F_0F0F, 32'h8000_0000, 32'h0000_0010, 32'h7FFF_FFFF};
  logic [31:0] vec_b [16] = '{32'h0000_0002, 32'h0000_0003, 32'h0000_000A, 32'hFFFF_FFFF,
                              32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000,
                              32'h4000_0000, 32'h0000_0001, 32'h0000_0001, 32'hF0F0_F0F0,
                              32'hF0F0_F0F0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
  logic [1:0]  vec_s [16] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b01,
                              2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
  logic        vec_c [16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] vec_g [16] = '{32'h0000_0003, 32'h0000_0007, 32'hFFFF_FFF9, 32'h1234_5678,
                              32'h1234_5677, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000,
                              32'h8000_0000, 32'h0000_0000, 32'h0001_0001, 32'hFFFF_FFFF,
                              32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0011, 32'h8000_0000};
  logic [3:0]  vec_f [16] = '{4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b1000, 4'b0001, 4'b1010,
                              4'b1110, 4'b0101, 4'b1010, 4'b0000, 4'b0001, 4'b1010, 4'b1100,
                              4'b0000, 4'b0101};

  // Scoreboard: expectation pushed on accept, compared on output handshake.
  logic [31:0] drv_exp_g;
  logic [3:0]  drv_exp_f;
  logic [35:0] exp_q [$];
  logic [35:0] sb_e;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check("sb_spurious_beat", 32'(out_valid), 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_g", g, sb_e[31:0]);
          check("sb_flags", 32'({cout, v, z, n}), 32'(sb_e[35:32]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back({drv_exp_f, drv_exp_g});
    end
  end

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] ts,
                       input logic tc, input logic [31:0] eg, input logic [3:0] ef);
    a = ta; b = tb; s = ts; cin = tc;
    drv_exp_g = eg; drv_exp_f = ef;
  endtask

  // Single beat into an idle pipeline; checks two-cycle latency and the result.
  task automatic send_beat(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] ts,
                           input logic tc, input logic [31:0] eg, input logic [3:0] ef,
                           input string tag);
    out_ready = 1'b1;
    drive(ta, tb, ts, tc, eg, ef);
    in_valid = 1'b1;
    @(negedge clk); #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_g"}, g, eg);
    check({tag, "_flags"}, 32'({cout, v, z, n}), 32'(ef));
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic send16(input logic [15:0] ta, input logic [15:0] tb, input logic [1:0] ts,
                        input logic tc, input logic [15:0] eg, input logic [3:0] ef,
                        input string tag);
    a16 = ta; b16 = tb; s16 = ts; cin16 = tc;
    in_valid16 = 1'b1;
    @(negedge clk); #1;
    check({tag, "_in_ready"}, 32'(in_ready16), 32'd1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid16), 32'd1);
    check({tag, "_g"}, 32'(g16), 32'(eg));
    check({tag, "_flags"}, 32'({cout16, v16, z16, n16}), 32'(ef));
    @(posedge clk); #1;
  endtask

  // Streams vectors [first, first+count); out_ready low for the first `stall` cycles.
  task automatic run_stream(input int first, input int count, input int stall,
                            input string tag, output int cycles);
    int idx;
    int cyc;
    int pop0;
    idx  = first;
    cyc  = 0;
    pop0 = n_pop;
    while ((idx < first + count || exp_q.size() != 0) && cyc < 200) begin
      out_ready = (cyc >= stall);
      in_valid  = (idx < first + count);
      if (in_valid) drive(vec_a[idx], vec_b[idx], vec_s[idx], vec_c[idx], vec_g[idx], vec_f[idx]);
      @(negedge clk); #1;
      if (stall > 0 && cyc >= 2 && cyc < stall) begin
        check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_stall_g"}, g, vec_g[first]);
      end
      if (in_valid && in_ready) idx++;
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cycles   = cyc;
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_beats_out"}, 32'(n_pop - pop0), 32'(count));
  endtask

  int cycles;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    drive(32'd0, 32'd0, 2'b00, 1'b0, 32'd0, 4'd0);
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    a16 = '0; b16 = '0; s16 = '0; cin16 = 1'b0;
`ifdef PIPELINED_CSEL_ALU_SAT_EN
    sat = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_g", g, 32'd0);
    check("rst_flags", 32'({cout, v, z, n}), 32'd0);
    check("rst_out_valid16", 32'(out_valid16), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    send_beat(32'h7FFF_FFFF, 32'h1, 2'b01, 1'b0, 32'h8000_0000, 4'b0101, "ovf_pos");
    send_beat(32'd5, 32'd5, 2'b10, 1'b1, 32'd0, 4'b1010, "sub_eq");

    run_stream(0, 16, 0, "stream", cycles);
    check("stream_cycles", 32'(cycles), 32'd18);

    run_stream(0, 16, 5, "stall", cycles);
    check("stall_cycles", 32'(cycles), 32'd21);

    send_beat(32'hFFFF_FFFF, 32'h0, 2'b00, 1'b1, 32'd0, 4'b1010, "carry_all");
    send16(16'hFFFF, 16'h0000, 2'b00, 1'b1, 16'h0000, 4'b1010, "w16_carry");
    send16(16'h7FFF, 16'h0000, 2'b00, 1'b1, 16'h8000, 4'b0101, "w16_ovf");

    // Two beats held in flight, then reset: neither may emerge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(vec_a[0], vec_b[0], vec_s[0], vec_c[0], vec_g[0], vec_f[0]);
    @(negedge clk); #1;
    @(posedge clk); #1;
    drive(vec_a[1], vec_b[1], vec_s[1], vec_c[1], vec_g[1], vec_f[1]);
    @(negedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_g", g, 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("flush_no_stale", 32'(out_valid), 32'd0);
    end

`ifdef PIPELINED_CSEL_ALU_SAT_EN
    sat = 1'b1;
    send_beat(32'h8000_0000, 32'h1, 2'b10, 1'b1, 32'h8000_0000, 4'b1101, "sat_neg");
    send_beat(32'h7FFF_FFFF, 32'h1, 2'b01, 1'b0, 32'h7FFF_FFFF, 4'b0100, "sat_pos");
    sat = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
